// File: rtl/router_pkg.sv
// Message layout helpers shared by the ring node and the message router.
// A message is {payload, id}, with the destination id in the low bits.
package router_pkg;
  localparam int MSG_MAX_W = 128;
  localparam int ID_LSB    = 0;

  function automatic logic [MSG_MAX_W-1:0] msg_id(input logic [MSG_MAX_W-1:0] msg,
                                                  input int proc_bits);
    return (msg >> ID_LSB) & ({MSG_MAX_W{1'b1}} >> (MSG_MAX_W - proc_bits));
  endfunction

  function automatic logic [MSG_MAX_W-1:0] msg_payload(input logic [MSG_MAX_W-1:0] msg,
                                                       input int proc_bits,
                                                       input int data_size);
    return (msg >> (ID_LSB + proc_bits)) & ({MSG_MAX_W{1'b1}} >> (MSG_MAX_W - data_size));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is visible the cycle after a push.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/message_ring_node.sv
// Ring node: delivers messages addressed to this node, forwards the rest, and
// injects round-robin-arbitrated local requests into idle output slots.
module message_ring_node
  import router_pkg::*;
#(
  parameter int                   PROC_BITS  = 4,
  parameter int                   DATA_SIZE  = 32,
  parameter logic [PROC_BITS-1:0] PROC_ID    = '0,
  parameter int                   NUM_CH     = 4,
  parameter int                   FIFO_DEPTH = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_CH-1:0]               req_valid_in,
  input  logic [NUM_CH*DATA_SIZE-1:0]     req_addr_in,
  input  logic [NUM_CH*PROC_BITS-1:0]     req_dst_in,
  output logic [NUM_CH-1:0]               req_ready_out,
  input  logic                            ring_valid_in,
  input  logic [DATA_SIZE+PROC_BITS-1:0]  ring_msg_in,
  output logic                            ring_ready_out,
  output logic                            ring_valid_out,
  output logic [DATA_SIZE+PROC_BITS-1:0]  ring_msg_out,
  input  logic                            ring_ready_in,
  output logic                            deliver_valid_out,
  output logic [DATA_SIZE-1:0]            deliver_data_out,
  input  logic                            deliver_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out
);
  localparam int MSG_W = DATA_SIZE + PROC_BITS;
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [MSG_W-1:0]     slot_msg_q, slot_msg_d;
  logic                 slot_vld_q, slot_vld_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [MSG_MAX_W-1:0] id_ext, pay_ext;
  logic [PROC_BITS-1:0] in_id;
  logic [DATA_SIZE-1:0] in_payload;
  logic                 in_is_hit, slot_free, pass_acc, hit_acc, inj_ok, inject;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic                 fifo_full, fifo_empty;
  logic                 unused_ok;
  int                   idx;

  assign id_ext     = msg_id(MSG_MAX_W'(ring_msg_in), PROC_BITS);
  assign pay_ext    = msg_payload(MSG_MAX_W'(ring_msg_in), PROC_BITS, DATA_SIZE);
  assign in_id      = id_ext[PROC_BITS-1:0];
  assign in_payload = pay_ext[DATA_SIZE-1:0];
  assign unused_ok  = ^{id_ext[MSG_MAX_W-1:PROC_BITS], pay_ext[MSG_MAX_W-1:DATA_SIZE]};

  assign in_is_hit      = (in_id == PROC_ID);
  assign slot_free      = !slot_vld_q || ring_ready_in;
  assign ring_ready_out = !rst_in && (in_is_hit ? !fifo_full : slot_free);
  assign hit_acc        = ring_valid_in && in_is_hit && ring_ready_out;
  assign pass_acc       = ring_valid_in && !in_is_hit && ring_ready_out;
  // Pass-through traffic always wins the output slot over local injection.
  assign inj_ok         = !rst_in && slot_free && !pass_acc;
  assign inject         = inj_ok && grant_found;
  assign ring_valid_out = slot_vld_q;
  assign ring_msg_out   = slot_msg_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && req_valid_in[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready_out = '0;
    if (inject) req_ready_out[grant_idx] = 1'b1;
  end

  always_comb begin
    slot_msg_d = slot_msg_q;
    slot_vld_d = slot_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (pass_acc) begin
      slot_msg_d = ring_msg_in;
      slot_vld_d = 1'b1;
    end else if (inject) begin
      slot_msg_d = {req_addr_in[grant_idx*DATA_SIZE +: DATA_SIZE],
                    req_dst_in[grant_idx*PROC_BITS +: PROC_BITS]};
      slot_vld_d = 1'b1;
    end else if (ring_ready_in) begin
      slot_vld_d = 1'b0;
    end
    if (inject) rr_ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_msg_q <= '0;
      slot_vld_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      slot_msg_q <= slot_msg_d;
      slot_vld_q <= slot_vld_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_deliver_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (hit_acc),
    .push_data (in_payload),
    .pop       (deliver_ready_in),
    .pop_data  (deliver_data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_out)
  );

  assign deliver_valid_out = !fifo_empty;
endmodule
